// File: rtl/tag_cmp_pkg.sv
// Shared types and helpers for the n-way tag comparator.
// Provides fallback values for the shared width defines, the FSM state enum,
// the tag-and-data (TAD) entry struct and bit-position helpers for the TAD layout.
// Optional feature macro used by the top: TAG_CMP_PERF_CNT_EN.

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 20
`endif
`ifndef BLANK_WIDTH
`define BLANK_WIDTH 2
`endif
`ifndef TAG_SIZE
`define TAG_SIZE 24
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 6
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 8
`endif

package tag_cmp_pkg;

    // Controller states: idle, then one state per dispatch class.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RHIT  = 3'd1,
        ST_RMISS = 3'd2,
        ST_WHIT  = 3'd3,
        ST_WMISS = 3'd4
    } tag_cmp_state_e;

    localparam int DEF_TAG_WIDTH   = `TAG_WIDTH;
    localparam int DEF_BLANK_WIDTH = `BLANK_WIDTH;
    localparam int DEF_DATA_WIDTH  = `AXI_DATA_WIDTH;
    localparam int DEF_TAG_SIZE    = `TAG_SIZE;
    localparam int DEF_ENTRY_WIDTH = DEF_TAG_SIZE + DEF_DATA_WIDTH;
    localparam int PERF_CNT_WIDTH  = 32;

    // One way of a set as it arrives on the R channel (metadata above data).
    typedef struct packed {
        logic                       valid;
        logic                       dirty;
        logic [DEF_TAG_WIDTH-1:0]   tag;
        logic [DEF_BLANK_WIDTH-1:0] blank;
        logic [DEF_DATA_WIDTH-1:0]  data;
    } tad_entry_t;

    // Bit positions inside one TAD entry of width entry_w (metadata is MSB first).
    function automatic int tad_valid_bit(input int entry_w);
        return entry_w - 1;
    endfunction

    function automatic int tad_dirty_bit(input int entry_w);
        return entry_w - 2;
    endfunction

    function automatic int tad_tag_msb(input int entry_w);
        return entry_w - 3;
    endfunction

    // Build a TAD entry with zero padding.
    function automatic tad_entry_t tad_make(input logic valid, input logic dirty,
                                            input logic [DEF_TAG_WIDTH-1:0] tag,
                                            input logic [DEF_DATA_WIDTH-1:0] data);
        tad_entry_t e;
        e.valid = valid;
        e.dirty = dirty;
        e.tag   = tag;
        e.blank = '0;
        e.data  = data;
        return e;
    endfunction

endpackage

// File: rtl/tag_compare_nway_way_sel.sv
// Combinational WAYS-wide tag match with priority encoders.
// Lowest matching way wins; lowest invalid way is reported for victim choice.
// multi_hit flags a set holding more than one matching way.

module tag_cmp_way_sel
    import tag_cmp_pkg::*;
#(
    parameter int WAYS      = 4,
    parameter int TAG_WIDTH = 20,
    parameter int WAY_WIDTH = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]                valid,
    input  logic [WAYS-1:0][TAG_WIDTH-1:0] tags,
    input  logic [TAG_WIDTH-1:0]           req_tag,
    output logic                           hit,
    output logic [WAY_WIDTH-1:0]           hit_way,
    output logic                           any_invalid,
    output logic [WAY_WIDTH-1:0]           first_invalid_way,
    output logic                           multi_hit
);

    logic [WAYS-1:0] match;

    for (genvar w = 0; w < WAYS; w++) begin : g_match
        assign match[w] = valid[w] && (tags[w] == req_tag);
    end

    // More than one bit set in the match vector.
    assign multi_hit = |(match & (match - WAYS'(1)));

    // Scan from the top way down so the lowest index is the last one written.
    always_comb begin
        hit               = 1'b0;
        hit_way           = '0;
        any_invalid       = 1'b0;
        first_invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                hit     = 1'b1;
                hit_way = WAY_WIDTH'(w);
            end
            if (!valid[w]) begin
                any_invalid       = 1'b1;
                first_invalid_way = WAY_WIDTH'(w);
            end
        end
    end

endmodule

// File: rtl/tag_compare_nway.sv
// WAYS-way set-associative tag comparator for the DRAM cache controller.
// Pops one request from the tag FIFO together with one R beat carrying the whole
// set, then dispatches: read hit -> ROB, read miss -> AR (+AW/W write-back on a
// dirty victim), write hit/miss -> fill arbiter (+AW/W write-back on a dirty victim).
// Handshakes: an output write/transfer happens in a cycle where the wren/valid
// output is high; wren outputs are only raised when the matching afull is low,
// so a wren pulse is itself the commit, and fill commits when fill_valid_o &
// fill_ready_i. Input pops (rready_o, *_rden_o) are single-cycle accept pulses.
// Optional macro TAG_CMP_PERF_CNT_EN adds hit/miss/write-back counters.

module tag_compare_nway
    import tag_cmp_pkg::*;
#(
    parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH   = `AXI_DATA_WIDTH,
    parameter int ID_WIDTH     = `AXI_ID_WIDTH,
    parameter int TAG_SIZE     = `TAG_SIZE,
    parameter int TAG_WIDTH    = `TAG_WIDTH,
    parameter int BLANK_WIDTH  = `BLANK_WIDTH,
    parameter int INDEX_WIDTH  = `INDEX_WIDTH,
    parameter int OFFSET_WIDTH = `OFFSET_WIDTH,
    parameter int TID_WIDTH    = `TID_WIDTH,
    parameter int WAYS         = 4,
    parameter int WAY_WIDTH    = $clog2(WAYS)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [ID_WIDTH-1:0]                        rid_i,
    input  logic [WAYS*(TAG_SIZE+DATA_WIDTH)-1:0]      rdata_i,
    input  logic                                       rvalid_i,
    output logic                                       rready_o,
    input  logic                                       tag_fifo_aempty_i,
    output logic                                       tag_fifo_rden_o,
    input  logic [TID_WIDTH+ADDR_WIDTH:0]              tag_fifo_data_i,
    input  logic                                       wbuffer_aempty_i,
    output logic                                       wbuffer_rden_o,
    input  logic [DATA_WIDTH-1:0]                      wbuffer_data_i,
    input  logic                                       rob_afull_i,
    output logic                                       rob_wren_o,
    output logic [TID_WIDTH+DATA_WIDTH-1:0]            rob_data_o,
    input  logic                                       ar_fifo_afull_i,
    output logic                                       ar_fifo_wren_o,
    output logic [TID_WIDTH+WAY_WIDTH+ADDR_WIDTH-1:0]  ar_fifo_data_o,
    input  logic                                       aw_fifo_afull_i,
    output logic                                       aw_fifo_wren_o,
    output logic [ADDR_WIDTH-1:0]                      aw_fifo_data_o,
    input  logic                                       w_fifo_afull_i,
    output logic                                       w_fifo_wren_o,
    output logic [DATA_WIDTH-1:0]                      w_fifo_data_o,
    input  logic                                       fill_ready_i,
    output logic                                       fill_valid_o,
    output logic [WAY_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_o,
    output logic [2:0]                                 state_o
`ifdef TAG_CMP_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0]                  hit_cnt_o,
    output logic [PERF_CNT_WIDTH-1:0]                  miss_cnt_o,
    output logic [PERF_CNT_WIDTH-1:0]                  wb_cnt_o
`endif
);

    localparam int E  = TAG_SIZE + DATA_WIDTH;
    localparam int LO = INDEX_WIDTH + OFFSET_WIDTH;

    tag_cmp_state_e state;
    logic [WAY_WIDTH-1:0] rr_ptr;
    logic hit_q;
    logic wb_q;

    // Per-way fields of the R beat.
    logic [WAYS-1:0]                 way_valid;
    logic [WAYS-1:0]                 way_dirty;
    logic [WAYS-1:0][TAG_WIDTH-1:0]  way_tag;
    logic [WAYS-1:0][DATA_WIDTH-1:0] way_data;

    for (genvar w = 0; w < WAYS; w++) begin : g_unpack
        assign way_valid[w] = rdata_i[w*E + tad_valid_bit(E)];
        assign way_dirty[w] = rdata_i[w*E + tad_dirty_bit(E)];
        assign way_tag[w]   = rdata_i[w*E + tad_tag_msb(E) -: TAG_WIDTH];
        assign way_data[w]  = rdata_i[w*E +: DATA_WIDTH];
    end

    // Request fields.
    logic                  req_write;
    logic [TID_WIDTH-1:0]  req_tid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [TAG_WIDTH-1:0]  req_tag;

    assign {req_write, req_tid, req_addr} = tag_fifo_data_i;
    assign req_tag = req_addr[ADDR_WIDTH-1:LO];

    logic                 hit;
    logic [WAY_WIDTH-1:0] hit_way;
    logic                 any_invalid;
    logic [WAY_WIDTH-1:0] first_invalid_way;
    logic                 multi_hit;

    tag_cmp_way_sel #(
        .WAYS      (WAYS),
        .TAG_WIDTH (TAG_WIDTH),
        .WAY_WIDTH (WAY_WIDTH)
    ) u_way_sel (
        .valid             (way_valid),
        .tags              (way_tag),
        .req_tag           (req_tag),
        .hit               (hit),
        .hit_way           (hit_way),
        .any_invalid       (any_invalid),
        .first_invalid_way (first_invalid_way),
        .multi_hit         (multi_hit)
    );

    // Victim: first invalid way, else the round-robin pointer.
    logic [WAY_WIDTH-1:0]  victim_way;
    logic [WAY_WIDTH-1:0]  sel_way;
    logic                  victim_wb;
    logic [ADDR_WIDTH-1:0] victim_addr;

    assign victim_way  = any_invalid ? first_invalid_way : rr_ptr;
    assign sel_way     = hit ? hit_way : victim_way;
    assign victim_wb   = !hit && way_valid[victim_way] && way_dirty[victim_way];
    assign victim_addr = {way_tag[victim_way], req_addr[LO-1:0]};

    // Accept only in IDLE with a beat, a request and (for writes) write data.
    logic accept;
    assign accept = !rst && (state == ST_IDLE) && rvalid_i && !tag_fifo_aempty_i &&
                    (!req_write || !wbuffer_aempty_i);

    assign rready_o        = accept;
    assign tag_fifo_rden_o = accept;
    assign wbuffer_rden_o  = accept && req_write;

    // Output strobes from the current state and downstream back-pressure.
    logic rob_we, ar_we, aw_we, w_we, fill_v, commit;

    always_comb begin
        rob_we = 1'b0;
        ar_we  = 1'b0;
        aw_we  = 1'b0;
        w_we   = 1'b0;
        fill_v = 1'b0;
        case (state)
            ST_RHIT: rob_we = !rob_afull_i;
            ST_RMISS: begin
                if (wb_q) begin
                    ar_we = !(ar_fifo_afull_i || aw_fifo_afull_i || w_fifo_afull_i);
                    aw_we = ar_we;
                    w_we  = ar_we;
                end else begin
                    ar_we = !ar_fifo_afull_i;
                end
            end
            ST_WHIT: fill_v = 1'b1;
            ST_WMISS: begin
                if (wb_q) begin
                    // Fill and write-back commit together.
                    fill_v = !aw_fifo_afull_i && !w_fifo_afull_i;
                    aw_we  = fill_v && fill_ready_i;
                    w_we   = fill_v && fill_ready_i;
                end else begin
                    fill_v = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign rob_wren_o     = rob_we;
    assign ar_fifo_wren_o = ar_we;
    assign aw_fifo_wren_o = aw_we;
    assign w_fifo_wren_o  = w_we;
    assign fill_valid_o   = fill_v;
    assign commit         = rob_we || ar_we || (fill_v && fill_ready_i);
    assign state_o        = 3'(state);

    // FSM, round-robin pointer and payload capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            hit_q          <= 1'b0;
            wb_q           <= 1'b0;
            rob_data_o     <= '0;
            ar_fifo_data_o <= '0;
            aw_fifo_data_o <= '0;
            w_fifo_data_o  <= '0;
            fill_data_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hit_q          <= hit;
                        wb_q           <= victim_wb;
                        rob_data_o     <= {req_tid, way_data[hit_way]};
                        ar_fifo_data_o <= {req_tid, sel_way, req_addr};
                        aw_fifo_data_o <= victim_addr;
                        w_fifo_data_o  <= way_data[victim_way];
                        fill_data_o    <= {sel_way, req_addr, wbuffer_data_i};
                        if (!hit && !any_invalid) begin
                            rr_ptr <= rr_ptr + WAY_WIDTH'(1);
                        end
                        if (req_write) begin
                            state <= hit ? ST_WHIT : ST_WMISS;
                        end else begin
                            state <= hit ? ST_RHIT : ST_RMISS;
                        end
                    end
                end
                default: begin
                    if (commit) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef TAG_CMP_PERF_CNT_EN
    // Saturating hit/miss/write-back counters, stepped in commit cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            wb_cnt_o   <= '0;
        end else if (commit) begin
            if (hit_q && (hit_cnt_o != '1)) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (!hit_q && (miss_cnt_o != '1)) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
            if (wb_q && (wb_cnt_o != '1)) begin
                wb_cnt_o <= wb_cnt_o + 32'd1;
            end
        end
    end
`endif

    // R ID and metadata padding carry no meaning here.
    logic unused_sink;
    assign unused_sink = ^{rid_i, rdata_i, hit_q};

    // Flag a set whose tag store holds the requested tag in more than one way.
    always @(posedge clk) begin
        if (!rst && accept) begin
            assert (!multi_hit) else $error("tag_compare_nway: multiple ways hit");
        end
    end

endmodule
